gpu_command_queue: RTL and testbench

//  - Command FIFO between the CPU/MMIO bus and the GPU control interface.
//  - Buffers draw/clear commands and replays each one to the GPU only when the GPU is idle.
//  - Drives the GPU's edge-triggered ctrl_draw/ctrl_clear strobes with correct setup timing,
//    so software can enqueue a burst of blits without polling busy.

---
 rtl/gpu_command_queue_if.sv | 56 +++++
 rtl/gpu_command_queue.sv | 175 +++++++++++++++++
 tb/tb_gpu_command_queue.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_command_queue_if.sv
// Bus bundle between the command producer (CPU/MMIO side plus GPU busy flag) and the
// command queue. The master modport is the environment; the slave modport is the queue.
interface gpu_command_queue_if #(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240,
    parameter int DEPTH     = 8
);
    localparam int XW = $clog2(FB_WIDTH) + 2;
    localparam int YW = $clog2(FB_HEIGHT) + 2;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [31:0]   cmd_address;
    logic [15:0]   cmd_address_x;
    logic [15:0]   cmd_address_y;
    logic [15:0]   cmd_image_width;
    logic [XW-1:0] cmd_width;
    logic [YW-1:0] cmd_height;
    logic [XW-1:0] cmd_x;
    logic [YW-1:0] cmd_y;
    logic [15:0]   cmd_clear_color;
    logic [CW-1:0] q_count;
    logic          q_idle;
    logic          gpu_busy;
    logic [31:0]   gpu_address;
    logic [15:0]   gpu_address_x;
    logic [15:0]   gpu_address_y;
    logic [15:0]   gpu_image_width;
    logic [XW-1:0] gpu_width;
    logic [YW-1:0] gpu_height;
    logic [XW-1:0] gpu_x;
    logic [YW-1:0] gpu_y;
    logic [15:0]   gpu_clear_color;
    logic          gpu_draw;
    logic          gpu_clear;

    modport master (
        output cmd_valid, cmd_op, cmd_address, cmd_address_x, cmd_address_y,
               cmd_image_width, cmd_width, cmd_height, cmd_x, cmd_y, cmd_clear_color,
               gpu_busy,
        input  cmd_ready, q_count, q_idle, gpu_address, gpu_address_x, gpu_address_y,
               gpu_image_width, gpu_width, gpu_height, gpu_x, gpu_y, gpu_clear_color,
               gpu_draw, gpu_clear
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_address, cmd_address_x, cmd_address_y,
               cmd_image_width, cmd_width, cmd_height, cmd_x, cmd_y, cmd_clear_color,
               gpu_busy,
        output cmd_ready, q_count, q_idle, gpu_address, gpu_address_x, gpu_address_y,
               gpu_image_width, gpu_width, gpu_height, gpu_x, gpu_y, gpu_clear_color,
               gpu_draw, gpu_clear
    );
endinterface

// File: rtl/gpu_command_queue.sv
// Command FIFO that replays draw/clear commands to an edge-triggered GPU control port.
// Optional macro GPU_QUEUE_CULL_EN: drop zero-area draw entries instead of issuing them.
module gpu_command_queue #(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240,
    parameter int DEPTH     = 8
) (
    input  logic                clk,
    input  logic                reset,
    gpu_command_queue_if.slave  bus
);
    localparam int XW = $clog2(FB_WIDTH) + 2;
    localparam int YW = $clog2(FB_HEIGHT) + 2;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic          op;
        logic [31:0]   address;
        logic [15:0]   address_x;
        logic [15:0]   address_y;
        logic [15:0]   image_width;
        logic [XW-1:0] width;
        logic [YW-1:0] height;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [15:0]   clear_color;
    } cmd_t;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        SETUP  = 4'b0010,
        STROBE = 4'b0100,
        WAIT   = 4'b1000
    } state_t;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    cmd_t          out_q, out_d;
    logic          draw_q, draw_d, clear_q, clear_d;
    logic          full_s, empty_s, push_s, pop_s, cull_s;
    cmd_t          head_s, in_s;

    function automatic logic is_cullable(input cmd_t c);
`ifdef GPU_QUEUE_CULL_EN
        return !c.op && ((c.width == XW'(0)) || (c.height == YW'(0)));
`else
        return 1'b0;
`endif
    endfunction

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == CW'(0));
    assign push_s  = bus.cmd_valid && !full_s;
    assign head_s  = mem_q[rd_ptr_q];
    assign cull_s  = is_cullable(head_s);

    // Pack the incoming command fields into one FIFO word
    always_comb begin
        in_s.op          = bus.cmd_op;
        in_s.address     = bus.cmd_address;
        in_s.address_x   = bus.cmd_address_x;
        in_s.address_y   = bus.cmd_address_y;
        in_s.image_width = bus.cmd_image_width;
        in_s.width       = bus.cmd_width;
        in_s.height      = bus.cmd_height;
        in_s.x           = bus.cmd_x;
        in_s.y           = bus.cmd_y;
        in_s.clear_color = bus.cmd_clear_color;
    end

    // Issue FSM: pops only when the GPU is idle; a culled head is consumed without leaving the popping state
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        draw_d  = 1'b0;
        clear_d = 1'b0;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_s && !bus.gpu_busy) begin
                    pop_s = 1'b1;
                    if (!cull_s) begin
                        out_d   = head_s;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                draw_d  = !out_q.op;
                clear_d = out_q.op;
                state_d = STROBE;
            end
            STROBE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!bus.gpu_busy) begin
                    if (!empty_s) begin
                        pop_s = 1'b1;
                        if (!cull_s) begin
                            out_d   = head_s;
                            state_d = SETUP;
                        end else begin
                            state_d = WAIT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = count_q + CW'(push_s) - CW'(pop_s);
    end

    // Storage array carries no reset; validity is tracked by the occupancy counter
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_s;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
            out_q    <= '0;
            draw_q   <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            draw_q   <= draw_d;
            clear_q  <= clear_d;
        end
    end

    assign bus.cmd_ready       = !full_s;
    assign bus.q_count         = count_q;
    assign bus.q_idle          = empty_s && (state_q == IDLE) && !bus.gpu_busy;
    assign bus.gpu_address     = out_q.address;
    assign bus.gpu_address_x   = out_q.address_x;
    assign bus.gpu_address_y   = out_q.address_y;
    assign bus.gpu_image_width = out_q.image_width;
    assign bus.gpu_width       = out_q.width;
    assign bus.gpu_height      = out_q.height;
    assign bus.gpu_x           = out_q.x;
    assign bus.gpu_y           = out_q.y;
    assign bus.gpu_clear_color = out_q.clear_color;
    assign bus.gpu_draw        = draw_q;
    assign bus.gpu_clear       = clear_q;
endmodule

// File: tb/tb_gpu_command_queue.sv
// Directed self-checking bench for gpu_command_queue; a simple GPU model holds busy
// for 50 cycles after each strobe, and a monitor logs every strobe with its cycle number.
module tb_gpu_command_queue;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic busy_force = 1'b0;
    logic busy_auto  = 1'b0;
    int   busy_cnt   = 0;

    logic        st_op  [64];
    logic [10:0] st_x   [64];
    logic [10:0] st_w   [64];
    logic [15:0] st_col [64];
    int          st_cyc [64];
    int          st_n = 0;
    logic        overlap = 1'b0;
    logic        adjacent = 1'b0;
    logic        prev_strobe = 1'b0;

    gpu_command_queue_if #(.FB_WIDTH(400), .FB_HEIGHT(240), .DEPTH(DEPTH)) bus_if ();

    gpu_command_queue #(.FB_WIDTH(400), .FB_HEIGHT(240), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // GPU model: busy for 50 cycles after each observed strobe
    always @(posedge clk) begin
        if (busy_auto && (bus_if.gpu_draw || bus_if.gpu_clear)) busy_cnt <= 50;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus_if.gpu_busy = busy_force || (busy_cnt != 0);

    // Strobe logger, sampled on the falling edge
    always @(negedge clk) begin
        if ((bus_if.gpu_draw || bus_if.gpu_clear) && st_n < 64) begin
            st_op[st_n]  <= bus_if.gpu_clear;
            st_x[st_n]   <= bus_if.gpu_x;
            st_w[st_n]   <= bus_if.gpu_width;
            st_col[st_n] <= bus_if.gpu_clear_color;
            st_cyc[st_n] <= cyc;
            st_n         <= st_n + 1;
        end
        if (bus_if.gpu_draw && bus_if.gpu_clear) overlap <= 1'b1;
        if ((bus_if.gpu_draw || bus_if.gpu_clear) && prev_strobe) adjacent <= 1'b1;
        prev_strobe <= bus_if.gpu_draw || bus_if.gpu_clear;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic op, input logic [10:0] x, input logic [10:0] w,
                        input logic [9:0] h, input logic [15:0] col,
                        output int acc_cyc, output logic accepted);
        bus_if.cmd_valid       = 1'b1;
        bus_if.cmd_op          = op;
        bus_if.cmd_address     = 32'h8000_0000 | {21'd0, x};
        bus_if.cmd_address_x   = 16'd0;
        bus_if.cmd_address_y   = 16'd0;
        bus_if.cmd_image_width = 16'd400;
        bus_if.cmd_width       = w;
        bus_if.cmd_height      = h;
        bus_if.cmd_x           = x;
        bus_if.cmd_y           = 10'd20;
        bus_if.cmd_clear_color = col;
        accepted = bus_if.cmd_ready;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        checks++; if (bus_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus_if.cmd_ready); end
        checks++; if (bus_if.q_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus_if.q_count); end
        checks++; if (bus_if.gpu_draw !== 1'b0 || bus_if.gpu_clear !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b expected 00", bus_if.gpu_draw, bus_if.gpu_clear); end
        checks++; if (bus_if.gpu_x !== 11'd0 || bus_if.gpu_address !== 32'd0) begin errors++; $display("FAIL reset_fields: got x=%0d addr=%0h expected 0", bus_if.gpu_x, bus_if.gpu_address); end
        checks++; if (bus_if.q_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", bus_if.q_idle); end
    endtask

    task automatic test_single_draw();
        int k; logic a; int b;
        b = st_n;
        push(1'b0, 11'd10, 11'd16, 10'd8, 16'd0, k, a);
        checks++; if (bus_if.q_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", bus_if.q_count); end
        tick(1);
        checks++; if (bus_if.gpu_x !== 11'd10 || bus_if.gpu_y !== 10'd20 || bus_if.gpu_width !== 11'd16 || bus_if.gpu_height !== 10'd8)
            begin errors++; $display("FAIL single_fields: got x=%0d y=%0d w=%0d h=%0d expected 10 20 16 8", bus_if.gpu_x, bus_if.gpu_y, bus_if.gpu_width, bus_if.gpu_height); end
        checks++; if (bus_if.gpu_draw !== 1'b0) begin errors++; $display("FAIL single_setup_strobe: got %b expected 0", bus_if.gpu_draw); end
        tick(1);
        checks++; if (bus_if.gpu_draw !== 1'b1) begin errors++; $display("FAIL single_strobe_high: got %b expected 1", bus_if.gpu_draw); end
        tick(1);
        checks++; if (bus_if.gpu_draw !== 1'b0) begin errors++; $display("FAIL single_strobe_low: got %b expected 0", bus_if.gpu_draw); end
        tick(3);
        checks++; if (st_n - b !== 1) begin errors++; $display("FAIL single_nstrobes: got %0d expected 1", st_n - b); end
        checks++; if (st_cyc[b] !== k + 2) begin errors++; $display("FAIL single_latency: got cycle %0d expected %0d", st_cyc[b], k + 2); end
        checks++; if (bus_if.gpu_x !== 11'd10) begin errors++; $display("FAIL single_hold: got %0d expected 10", bus_if.gpu_x); end
    endtask

    task automatic test_busy_order();
        int k; logic a; int b;
        b = st_n;
        busy_force = 1'b1;
        for (int i = 1; i <= 3; i++) push(1'b0, 11'(i), 11'd4, 10'd4, 16'd0, k, a);
        checks++; if (bus_if.q_count !== 4'd3) begin errors++; $display("FAIL order_count3: got %0d expected 3", bus_if.q_count); end
        busy_auto = 1'b1;
        busy_force = 1'b0;
        tick(1);
        checks++; if (bus_if.q_count !== 4'd2) begin errors++; $display("FAIL order_count2: got %0d expected 2", bus_if.q_count); end
        tick(169);
        checks++; if (st_n - b !== 3) begin errors++; $display("FAIL order_nstrobes: got %0d expected 3", st_n - b); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (st_x[b + i] !== 11'(i + 1)) begin errors++; $display("FAIL order_x%0d: got %0d expected %0d", i, st_x[b + i], i + 1); end
        end
        checks++; if (st_cyc[b + 1] - st_cyc[b] !== 53) begin errors++; $display("FAIL order_gap1: got %0d expected 53", st_cyc[b + 1] - st_cyc[b]); end
        checks++; if (st_cyc[b + 2] - st_cyc[b + 1] !== 53) begin errors++; $display("FAIL order_gap2: got %0d expected 53", st_cyc[b + 2] - st_cyc[b + 1]); end
        checks++; if (bus_if.q_count !== 4'd0 || bus_if.q_idle !== 1'b1) begin errors++; $display("FAIL order_drained: got count=%0d idle=%b expected 0 1", bus_if.q_count, bus_if.q_idle); end
    endtask

    task automatic test_full();
        int k; logic a; int b; int acc;
        b = st_n;
        acc = 0;
        busy_force = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(1'b0, 11'(i), 11'd4, 10'd4, 16'd0, k, a);
            if (a) acc++;
        end
        checks++; if (acc !== DEPTH) begin errors++; $display("FAIL full_accepted: got %0d expected %0d", acc, DEPTH); end
        checks++; if (bus_if.q_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", bus_if.q_count); end
        checks++; if (bus_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", bus_if.cmd_ready); end
        // push offered while full, in the same cycle as the first pop: must be dropped
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_x = 11'd99;
        busy_force = 1'b0;
        tick(1);
        bus_if.cmd_valid = 1'b0;
        checks++; if (bus_if.q_count !== 4'd7) begin errors++; $display("FAIL full_push_pop: got %0d expected 7", bus_if.q_count); end
        tick(434);
        checks++; if (st_n - b !== 8) begin errors++; $display("FAIL full_nstrobes: got %0d expected 8", st_n - b); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (st_x[b + i] !== 11'(i)) begin errors++; $display("FAIL full_x%0d: got %0d expected %0d", i, st_x[b + i], i); end
        end
        checks++; if (bus_if.q_count !== 4'd0) begin errors++; $display("FAIL full_drained: got %0d expected 0", bus_if.q_count); end
    endtask

    task automatic test_clear_then_draw();
        int k; int k2; logic a; int b;
        b = st_n;
        push(1'b1, 11'd0, 11'd0, 10'd0, 16'hF801, k, a);
        push(1'b0, 11'd5, 11'd4, 10'd4, 16'd0, k2, a);
        tick(70);
        checks++; if (st_n - b !== 2) begin errors++; $display("FAIL clr_nstrobes: got %0d expected 2", st_n - b); end
        checks++; if (st_op[b] !== 1'b1 || st_col[b] !== 16'hF801) begin errors++; $display("FAIL clr_first: got op=%b col=%0h expected 1 f801", st_op[b], st_col[b]); end
        checks++; if (st_cyc[b] !== k + 2) begin errors++; $display("FAIL clr_latency: got %0d expected %0d", st_cyc[b], k + 2); end
        checks++; if (st_op[b + 1] !== 1'b0 || st_x[b + 1] !== 11'd5) begin errors++; $display("FAIL clr_second: got op=%b x=%0d expected 0 5", st_op[b + 1], st_x[b + 1]); end
        checks++; if (overlap !== 1'b0 || adjacent !== 1'b0) begin errors++; $display("FAIL clr_separation: got overlap=%b adjacent=%b expected 0 0", overlap, adjacent); end
        tick(60);
    endtask

    task automatic test_reset_in_wait();
        int k; logic a; int b;
        busy_force = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b0, 11'(20 + i), 11'd4, 10'd4, 16'd0, k, a);
        busy_force = 1'b0;
        tick(9);
        checks++; if (bus_if.q_count !== 4'd2) begin errors++; $display("FAIL rstw_pre_count: got %0d expected 2", bus_if.q_count); end
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        b = st_n;
        checks++; if (bus_if.q_count !== 4'd0 || bus_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstw_count: got count=%0d ready=%b expected 0 1", bus_if.q_count, bus_if.cmd_ready); end
        checks++; if (bus_if.gpu_draw !== 1'b0 || bus_if.gpu_x !== 11'd0) begin errors++; $display("FAIL rstw_outputs: got draw=%b x=%0d expected 0 0", bus_if.gpu_draw, bus_if.gpu_x); end
        tick(120);
        checks++; if (st_n !== b) begin errors++; $display("FAIL rstw_no_strobe: got %0d expected %0d", st_n - b, 0); end
    endtask

    task automatic test_cull();
        int k; logic a; int b; int exp_n;
`ifdef GPU_QUEUE_CULL_EN
        exp_n = 1;
`else
        exp_n = 2;
`endif
        b = st_n;
        push(1'b0, 11'd7, 11'd0, 10'd4, 16'd0, k, a);
        push(1'b0, 11'd8, 11'd4, 10'd4, 16'd0, k, a);
        tick(130);
        checks++; if (st_n - b !== exp_n) begin errors++; $display("FAIL cull_nstrobes: got %0d expected %0d", st_n - b, exp_n); end
        checks++; if (st_w[st_n - 1] !== 11'd4 || st_x[st_n - 1] !== 11'd8) begin errors++; $display("FAIL cull_last: got w=%0d x=%0d expected 4 8", st_w[st_n - 1], st_x[st_n - 1]); end
        checks++; if (bus_if.q_count !== 4'd0) begin errors++; $display("FAIL cull_drained: got %0d expected 0", bus_if.q_count); end
    endtask

    initial begin
        bus_if.cmd_valid       = 1'b0;
        bus_if.cmd_op          = 1'b0;
        bus_if.cmd_address     = 32'd0;
        bus_if.cmd_address_x   = 16'd0;
        bus_if.cmd_address_y   = 16'd0;
        bus_if.cmd_image_width = 16'd0;
        bus_if.cmd_width       = 11'd0;
        bus_if.cmd_height      = 10'd0;
        bus_if.cmd_x           = 11'd0;
        bus_if.cmd_y           = 10'd0;
        bus_if.cmd_clear_color = 16'd0;
        #1;
        test_reset();
        test_single_draw();
        test_busy_order();
        test_full();
        test_clear_then_draw();
        test_reset_in_wait();
        test_cull();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
